vend_dispense_ctrl: RTL and testbench

Customer-side purchase controller for the vending machine, sitting directly downstream of the supply-charging stage. Holds the 8-entry product table (11-bit entries) written by the charging stage and accumulates coin credit. On a selection it checks price and stock, issues a one-cycle dispense pulse, decrements the stored quantity and returns change. Raises `redlight` on any refused purchase.

---
 rtl/vend_dispense_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vend_dispense_ctrl.sv
// ============================================================================
// Module      : vend_dispense_ctrl
// Description : Vending purchase controller. It holds the product table,
//               accumulates coin credit, and vends with change return.
//               Optional macro VEND_TIMEOUT_EN adds an inactivity refund.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_dispense_ctrl #(
    parameter int CREDIT_W       = 5,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [2:0]          load_idx,
    input  logic [10:0]         load_data,
    input  logic                coin_valid,
    input  logic [3:0]          coin_value,
    output logic                coin_reject,
    input  logic                select_valid,
    input  logic [2:0]          select_idx,
    input  logic                cancel,
    output logic                dispense_valid,
    output logic [2:0]          dispense_id,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amount,
    output logic [CREDIT_W-1:0] credit,
    output logic                redlight,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CREDIT = 3'd1,
        S_CHECK  = 3'd2,
        S_VEND   = 3'd3,
        S_CHANGE = 3'd4
    } state_t;

    state_t              r_state;
    logic [10:0]         r_table [0:7];
    logic [2:0]          r_sel_idx;

    logic [10:0]         w_entry;
    logic [3:0]          w_qty;
    logic [3:0]          w_price;
    logic [CREDIT_W-1:0] w_price_ext;
    logic [CREDIT_W-1:0] w_left;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin;
    logic                w_refuse;
    logic                w_timeout;

    assign w_entry     = r_table[r_sel_idx];
    assign w_qty       = w_entry[7:4];
    assign w_price     = w_entry[3:0];
    assign w_price_ext = CREDIT_W'(w_price);
    assign w_left      = credit - w_price_ext;
    assign w_coin      = coin_valid && (coin_value != 4'd0);
    // One extra bit catches overflow instead of wrapping.
    assign w_sum       = (CREDIT_W+1)'(credit) + (CREDIT_W+1)'(coin_value);
    assign w_refuse    = (w_qty == 4'd0) || (w_price == 4'd0) || (w_price_ext > credit);

`ifdef VEND_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CNT_W-1:0] r_idle_cnt;

    assign w_timeout = (r_idle_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset || (r_state != S_CREDIT) || w_coin || select_valid) begin
            r_idle_cnt <= '0;
        end else if (!w_timeout) begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Loads are blocked while in CHECK/VEND, so they never collide with the decrement.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                r_table[i] <= '0;
            end
        end else if (load_valid && load_ready) begin
            r_table[load_idx] <= load_data;
        end else if (r_state == S_VEND) begin
            r_table[r_sel_idx][7:4] <= w_qty - 4'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_sel_idx      <= '0;
            credit         <= '0;
            redlight       <= 1'b0;
            dispense_valid <= 1'b0;
            dispense_id    <= '0;
            change_valid   <= 1'b0;
            change_amount  <= '0;
            coin_reject    <= 1'b0;
            busy           <= 1'b0;
            load_ready     <= 1'b1;
        end else begin
            dispense_valid <= 1'b0;
            change_valid   <= 1'b0;
            coin_reject    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_coin) begin
                        credit   <= CREDIT_W'(coin_value);
                        redlight <= 1'b0;
                        r_state  <= S_CREDIT;
                    end
                end
                S_CREDIT: begin
                    if (cancel || (w_timeout && !w_coin && !select_valid)) begin
                        coin_reject <= w_coin;
                        redlight    <= cancel ? 1'b0 : redlight;
                        r_state     <= S_CHANGE;
                        busy        <= 1'b1;
                        if (credit != '0) begin
                            change_valid  <= 1'b1;
                            change_amount <= credit;
                        end
                    end else if (select_valid) begin
                        coin_reject <= w_coin;
                        redlight    <= 1'b0;
                        r_sel_idx   <= select_idx;
                        r_state     <= S_CHECK;
                        busy        <= 1'b1;
                        load_ready  <= 1'b0;
                    end else if (w_coin) begin
                        if (w_sum[CREDIT_W]) begin
                            coin_reject <= 1'b1;
                        end else begin
                            credit   <= w_sum[CREDIT_W-1:0];
                            redlight <= 1'b0;
                        end
                    end
                end
                S_CHECK: begin
                    coin_reject <= w_coin;
                    if (w_refuse) begin
                        redlight   <= 1'b1;
                        r_state    <= S_CREDIT;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                    end else begin
                        dispense_valid <= 1'b1;
                        dispense_id    <= w_entry[10:8];
                        r_state        <= S_VEND;
                    end
                end
                S_VEND: begin
                    // Change pulse is issued on entry so it coincides with the CHANGE cycle.
                    coin_reject <= w_coin;
                    credit      <= w_left;
                    r_state     <= S_CHANGE;
                    load_ready  <= 1'b1;
                    if (w_left != '0) begin
                        change_valid  <= 1'b1;
                        change_amount <= w_left;
                    end
                end
                S_CHANGE: begin
                    coin_reject <= w_coin;
                    credit      <= '0;
                    r_state     <= S_IDLE;
                    busy        <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    credit     <= '0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_vend_dispense_ctrl.sv
// ============================================================================
// Module      : tb_vend_dispense_ctrl
// Description : Scoreboard bench for vend_dispense_ctrl (honours VEND_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vend_dispense_ctrl;

`ifdef VEND_TIMEOUT_EN
    localparam int c_TO = 20;
`else
    localparam int c_TO = 1000;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [2:0]  load_idx = '0;
    logic [10:0] load_data = '0;
    logic        coin_valid = 1'b0;
    logic [3:0]  coin_value = '0;
    logic        coin_reject;
    logic        select_valid = 1'b0;
    logic [2:0]  select_idx = '0;
    logic        cancel = 1'b0;
    logic        dispense_valid;
    logic [2:0]  dispense_id;
    logic        change_valid;
    logic [4:0]  change_amount;
    logic [4:0]  credit;
    logic        redlight;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] q_disp [$];
    logic [4:0] q_chg  [$];
    int         q_rej  [$];

    vend_dispense_ctrl #(.CREDIT_W(5), .TIMEOUT_CYCLES(c_TO)) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_idx(load_idx), .load_data(load_data),
        .coin_valid(coin_valid), .coin_value(coin_value), .coin_reject(coin_reject),
        .select_valid(select_valid), .select_idx(select_idx), .cancel(cancel),
        .dispense_valid(dispense_valid), .dispense_id(dispense_id),
        .change_valid(change_valid), .change_amount(change_amount),
        .credit(credit), .redlight(redlight), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Monitor: every output pulse must match the head of its queue.
    always @(negedge clock) begin
        if (dispense_valid === 1'b1) begin
            n_checks++;
            if (q_disp.size() == 0) begin
                n_errors++;
                $display("FAIL dispense_unexpected: got id %0d expected no dispense", dispense_id);
            end else begin
                logic [2:0] e;
                e = q_disp.pop_front();
                if (dispense_id !== e) begin
                    n_errors++;
                    $display("FAIL dispense_id: got %0d expected %0d", dispense_id, e);
                end
            end
        end
        if (change_valid === 1'b1) begin
            n_checks++;
            if (q_chg.size() == 0) begin
                n_errors++;
                $display("FAIL change_unexpected: got %0d expected no change", change_amount);
            end else begin
                logic [4:0] e;
                e = q_chg.pop_front();
                if (change_amount !== e) begin
                    n_errors++;
                    $display("FAIL change_amount: got %0d expected %0d", change_amount, e);
                end
            end
        end
        if (coin_reject === 1'b1) begin
            n_checks++;
            if (q_rej.size() == 0) begin
                n_errors++;
                $display("FAIL coin_reject_unexpected: got 1 expected 0");
            end else begin
                void'(q_rej.pop_front());
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [2:0] idx, input logic [2:0] id,
                           input logic [3:0] qty, input logic [3:0] price);
        bit done;
        done       = 1'b0;
        load_valid = 1'b1;
        load_idx   = idx;
        load_data  = {id, qty, price};
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clock);
            if (load_ready) begin
                step();
                done = 1'b1;
            end
        end
        load_valid = 1'b0;
        chk("load_accepted", int'(done), 1);
    endtask

    task automatic do_coin(input logic [3:0] v);
        coin_valid = 1'b1;
        coin_value = v;
        step();
        coin_valid = 1'b0;
        coin_value = '0;
    endtask

    task automatic do_select(input logic [2:0] idx);
        select_valid = 1'b1;
        select_idx   = idx;
        step();
        select_valid = 1'b0;
    endtask

    task automatic do_cancel();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
    endtask

    initial begin
        // Reset state
        wait_cycles(3);
        reset = 1'b0;
        step();
        chk("rst_credit", int'(credit), 0);
        chk("rst_redlight", int'(redlight), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_load_ready", int'(load_ready), 1);
        chk("rst_dispense_valid", int'(dispense_valid), 0);
        chk("rst_change_valid", int'(change_valid), 0);

        // Basic purchase with change
        do_load(3'd2, 3'd5, 4'd3, 4'd4);
        do_coin(4'd3);
        do_coin(4'd2);
        chk("t1_credit", int'(credit), 5);
        q_disp.push_back(3'd5);
        q_chg.push_back(5'd1);
        do_select(3'd2);
        chk("t1_busy_check", int'(busy), 1);
        chk("t1_load_ready_check", int'(load_ready), 0);
        wait_cycles(3);
        chk("t1_busy_idle", int'(busy), 0);
        chk("t1_credit_idle", int'(credit), 0);

        // Exact price with timing; qty now 2 so two buys succeed, the third is refused
        do_coin(4'd4);
        q_disp.push_back(3'd5);
        do_select(3'd2);
        step();
        chk("t5_dispense_cycle", int'(dispense_valid), 1);
        chk("t5_dispense_id", int'(dispense_id), 5);
        step();
        chk("t5_no_change", int'(change_valid), 0);
        chk("t5_busy_change", int'(busy), 1);
        step();
        chk("t5_idle_busy", int'(busy), 0);
        chk("t5_idle_credit", int'(credit), 0);
        do_coin(4'd4);
        q_disp.push_back(3'd5);
        do_select(3'd2);
        wait_cycles(3);
        do_coin(4'd4);
        do_select(3'd2);
        step();
        chk("t1_qty_empty_redlight", int'(redlight), 1);
        q_chg.push_back(5'd4);
        do_cancel();
        wait_cycles(2);

        // Zero-quantity refusal then cancel
        do_load(3'd0, 3'd1, 4'd0, 4'd3);
        do_coin(4'd10);
        chk("t2_credit", int'(credit), 10);
        do_select(3'd0);
        step();
        chk("t2_redlight", int'(redlight), 1);
        chk("t2_busy", int'(busy), 0);
        chk("t2_credit_kept", int'(credit), 10);
        q_chg.push_back(5'd10);
        do_cancel();
        chk("t2_redlight_clear", int'(redlight), 0);
        wait_cycles(2);
        chk("t2_credit_zero", int'(credit), 0);

        // Credit overflow boundary
        do_coin(4'd15);
        do_coin(4'd15);
        chk("t3_credit30", int'(credit), 30);
        q_rej.push_back(1);
        do_coin(4'd2);
        chk("t3_credit_after_reject", int'(credit), 30);
        do_coin(4'd1);
        chk("t3_credit31", int'(credit), 31);
        q_chg.push_back(5'd31);
        do_cancel();
        wait_cycles(2);

        // Load held through a vend, completing in CHANGE
        do_load(3'd2, 3'd5, 4'd5, 4'd4);
        do_coin(4'd4);
        q_disp.push_back(3'd5);
        do_select(3'd2);
        load_valid = 1'b1;
        load_idx   = 3'd2;
        load_data  = {3'd6, 4'd1, 4'd2};
        chk("t4_ready_check", int'(load_ready), 0);
        step();
        chk("t4_ready_vend", int'(load_ready), 0);
        step();
        chk("t4_ready_change", int'(load_ready), 1);
        step();
        load_valid = 1'b0;
        do_coin(4'd2);
        q_disp.push_back(3'd6);
        do_select(3'd2);
        wait_cycles(3);
        do_coin(4'd2);
        do_select(3'd2);
        step();
        chk("t4_overwrite_qty_redlight", int'(redlight), 1);
        q_chg.push_back(5'd2);
        do_cancel();
        wait_cycles(2);

        // Reset during CHECK
        do_load(3'd3, 3'd7, 4'd2, 4'd3);
        do_coin(4'd5);
        do_select(3'd3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_credit", int'(credit), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_dispense", int'(dispense_valid), 0);
        wait_cycles(3);
        chk("t6_idle_busy", int'(busy), 0);

        // Inactivity
        do_coin(4'd7);
`ifdef VEND_TIMEOUT_EN
        q_chg.push_back(5'd7);
        wait_cycles(c_TO + 5);
        chk("t7_timeout_credit", int'(credit), 0);
`else
        wait_cycles(1000);
        chk("t7_no_timeout_credit", int'(credit), 7);
        chk("t7_no_timeout_busy", int'(busy), 0);
        q_chg.push_back(5'd7);
        do_cancel();
        wait_cycles(2);
`endif

        wait_cycles(3);
        chk("end_disp_queue", q_disp.size(), 0);
        chk("end_chg_queue", q_chg.size(), 0);
        chk("end_rej_queue", q_rej.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
